uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the team's UART transmitter; same frame format and parity convention.
- Oversamples the serial line by a runtime Prescale, majority-votes three mid-bit samples and deserializes LSB-first.
- Checks the optional parity bit and the stop bit, then presents a parallel word with a one-cycle valid strobe to the system controller.

Parameters:
- width, 8, data bits per frame.

Ports:
- CLK  input  1  system clock (Prescale x baud).
- Reset  input  1  reset, asynchronous, active-low.
- Rx_in  input  1  serial line; idles high; asynchronous to CLK.
- Parity_type  input  1  0 = even, 1 = odd parity.
- Parity_EN  input  1  1 = frame carries a parity bit.
- Prescale  input  6  oversampling ratio; legal values are even, 8..32.
- P_Data  output  width  received word; held until the next good frame.
- Data_valid  output  1  one-cycle pulse: P_Data updated, frame error-free.
- Parity_error  output  1  one-cycle pulse: parity mismatch.
- Stop_error  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset: all outputs 0, P_Data 0, synchronizer flops 1, FSM IDLE, all counters 0.
- Rx_in passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rx`.
- Frame: start(0), width data bits LSB first, optional parity, stop(1). F = 2 + width + Parity_EN bits.
- Prescale and Parity_EN/Parity_type are latched on IDLE->START. Changes mid-frame have no effect on that frame.
- edge_cnt runs 0..P-1 per bit (P = latched Prescale), wraps to 0 at P-1, and advances bit_cnt.
- Sampling: rx is captured at edge_cnt = P/2-1, P/2 and P/2+1. Bit value = majority of the three samples.
- FSM states:
  - IDLE: rx = 0 -> START, edge_cnt = 1 (the detect cycle counts as edge 0). Otherwise stay.
  - START: at edge_cnt = P-1, voted bit 0 -> DATA, bit_cnt = 0. Voted bit 1 (glitch) -> IDLE, no output pulses.
  - DATA: at each edge_cnt = P-1, shift the voted bit into shift_reg[bit_cnt] and increment bit_cnt. After bit width-1: Parity_EN -> PARITY, else -> STOP.
  - PARITY: at edge_cnt = P-1, store the voted bit. Expected = Parity_type ? ~^shift_reg : ^shift_reg. Mismatch sets an internal par_err flag. -> STOP.
  - STOP: at edge_cnt = P-1, evaluate the frame (outputs registered, visible the next cycle):
    - voted stop 0 -> Stop_error = 1.
    - par_err set -> Parity_error = 1.
    - neither -> P_Data <= shift_reg and Data_valid = 1.
    - Both errors may pulse in the same cycle. Data_valid is never asserted alongside an error; P_Data is unchanged on an error.
    - -> IDLE. par_err is cleared.
- Latency: Rx_in falls before CLK edge k -> Data_valid is high in the cycle after edge k+1+F*P.
- Back-to-back frames: a start bit immediately following the stop bit is detected in IDLE with at most 1 cycle of added slip. With P >= 8 the mid-bit sampling still holds.
- An error pulse and the next start-bit detection may coincide; the pulse is not lost.
- Reset asserted mid-frame: immediate return to the reset state, partial word discarded, no pulses.
- Line held low (break): the frame ends with Stop_error, then the FSM restarts START detection while rx stays 0.

Test Plan:
- Prescale = 8, Parity_EN = 1, Parity_type = 0, frame 0xA5 with parity bit 0, stop 1 -> P_Data = 0xA5, Data_valid exactly 1 cycle, at edge k+1+11*8+1; both error flags stay 0.
- Prescale = 16, Parity_type = 1, frame 0x3C with parity bit 1 -> P_Data = 0x3C, Data_valid. Repeat with parity bit 0 -> Parity_error pulse, no Data_valid, P_Data stays 0x3C.
- Prescale = 8, Parity_EN = 0, frame 0x5A with stop bit forced 0 -> Stop_error 1 cycle, no Data_valid. Next good frame 0x01 -> Data_valid, P_Data = 0x01.
- Rx_in low pulse of 2 CLK cycles, Prescale = 8 -> no pulses; FSM back in IDLE by edge 8; a following frame 0x77 is received correctly.
- Prescale = 32, back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three Data_valid pulses, 32*F (+/-1) cycles apart, with correct data. Single 1-cycle mid-bit glitches are voted out.
- Reset pulsed during DATA bit 4 of frame 0xC3 -> outputs 0, no pulse; the next full frame 0x42 -> P_Data = 0x42.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Three mid-bit samples are majority
// voted, data is shifted in LSB-first, then parity and stop bit are checked.
module uart_rx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Rx_in,
    input  logic             Parity_type,
    input  logic             Parity_EN,
    input  logic [5:0]       Prescale,
    output logic [width-1:0] P_Data,
    output logic             Data_valid,
    output logic             Parity_error,
    output logic             Stop_error
);
    localparam int BCW = (width > 1) ? $clog2(width) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(width - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic parity_bit(input logic [width-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    logic             rx_meta_q, rx_meta_d;
    logic             rx_q, rx_d;
    state_t           state_q, state_d;
    logic [5:0]       edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]       samp_q, samp_d;
    logic [width-1:0] shift_q, shift_d;
    logic [5:0]       prescale_q, prescale_d;
    logic             par_en_q, par_en_d;
    logic             par_type_q, par_type_d;
    logic             par_err_q, par_err_d;
    logic [width-1:0] p_data_q, p_data_d;
    logic             data_valid_q, data_valid_d;
    logic             parity_error_q, parity_error_d;
    logic             stop_error_q, stop_error_d;

    logic [5:0]       half_s;
    logic             last_edge_s;
    logic             vote_s;

    assign half_s      = {1'b0, prescale_q[5:1]};
    assign last_edge_s = (edge_cnt_q == (prescale_q - 6'd1));
    assign vote_s      = maj3(samp_q);

    // Next-state, bit timing, sampling and frame evaluation
    always_comb begin
        rx_meta_d      = Rx_in;
        rx_d           = rx_meta_q;
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        samp_d         = samp_q;
        shift_d        = shift_q;
        prescale_d     = prescale_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        par_err_d      = par_err_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        if (state_q != IDLE) begin
            if (last_edge_s) begin
                edge_cnt_d = 6'd0;
            end else begin
                edge_cnt_d = edge_cnt_q + 6'd1;
            end
            if (edge_cnt_q == (half_s - 6'd1)) begin
                samp_d[0] = rx_q;
            end else if (edge_cnt_q == half_s) begin
                samp_d[1] = rx_q;
            end else if (edge_cnt_q == (half_s + 6'd1)) begin
                samp_d[2] = rx_q;
            end else begin
                samp_d = samp_q;
            end
        end else begin
            edge_cnt_d = 6'd0;
        end

        case (state_q)
            IDLE: begin
                // Detect cycle is edge 0, so the next cycle starts at 1
                if (!rx_q) begin
                    state_d    = START;
                    edge_cnt_d = 6'd1;
                    prescale_d = Prescale;
                    par_en_d   = Parity_EN;
                    par_type_d = Parity_type;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (last_edge_s) begin
                    if (!vote_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (last_edge_s) begin
                    shift_d[bit_cnt_q] = vote_s;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (last_edge_s) begin
                    if (vote_s != parity_bit(shift_q, par_type_q)) begin
                        par_err_d = 1'b1;
                    end else begin
                        par_err_d = par_err_q;
                    end
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (last_edge_s) begin
                    stop_error_d   = ~vote_s;
                    parity_error_d = par_err_q;
                    if (vote_s && !par_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        p_data_d = p_data_q;
                    end
                    par_err_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronizer resets to the idle line level
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rx_meta_q      <= 1'b1;
            rx_q           <= 1'b1;
            state_q        <= IDLE;
            edge_cnt_q     <= 6'd0;
            bit_cnt_q      <= '0;
            samp_q         <= 3'd0;
            shift_q        <= '0;
            prescale_q     <= 6'd0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            par_err_q      <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            rx_meta_q      <= rx_meta_d;
            rx_q           <= rx_d;
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            samp_q         <= samp_d;
            shift_q        <= shift_d;
            prescale_q     <= prescale_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            par_err_q      <= par_err_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign P_Data       = p_data_q;
    assign Data_valid   = data_valid_q;
    assign Parity_error = parity_error_q;
    assign Stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialized by the bench, expected
// outcomes are queued at send time and matched against the strobes.
module tb_uart_rx;
    logic       CLK;
    logic       Reset;
    logic       Rx_in;
    logic       Parity_type;
    logic       Parity_EN;
    logic [5:0] Prescale;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Parity_error;
    logic       Stop_error;

    uart_rx #(.width(8)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Rx_in       (Rx_in),
        .Parity_type (Parity_type),
        .Parity_EN   (Parity_EN),
        .Prescale    (Prescale),
        .P_Data      (P_Data),
        .Data_valid  (Data_valid),
        .Parity_error(Parity_error),
        .Stop_error  (Stop_error)
    );

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
        int         cyc;
        int         tol;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    logic [7:0] last_good = 8'h00;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Match every strobe cycle against the oldest queued expectation
    always @(negedge CLK) begin
        if (Reset === 1'b1 && (Data_valid || Parity_error || Stop_error)) begin
            chk("pulse_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("data_valid", 32'(Data_valid), 32'(mon_e.dv));
                chk("parity_error", 32'(Parity_error), 32'(mon_e.pe));
                chk("stop_error", 32'(Stop_error), 32'(mon_e.se));
                chk("p_data", 32'(P_Data), 32'(mon_e.pdata));
                if (mon_e.tol == 0) begin
                    chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                end else begin
                    chk("pulse_window",
                        32'((cyc >= mon_e.cyc - mon_e.tol) && (cyc <= mon_e.cyc + mon_e.tol)),
                        32'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b, input int p, input logic glitch);
        Rx_in = b;
        if (glitch) begin
            repeat (p / 2) @(posedge CLK);
            #1 Rx_in = ~b;
            @(posedge CLK);
            #1 Rx_in = b;
            repeat (p - p / 2 - 1) @(posedge CLK);
        end else begin
            repeat (p) @(posedge CLK);
        end
        #1;
    endtask

    task automatic idle(input int n);
        Rx_in = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptype, input logic par_flip,
                              input logic stop_b, input int glitch_bit, input int tol);
        exp_t e;
        logic par;
        Prescale    = p[5:0];
        Parity_EN   = pen;
        Parity_type = ptype;
        par  = (ptype ? ~^d : ^d) ^ par_flip;
        e.se = ~stop_b;
        e.pe = pen & par_flip;
        e.dv = ~e.se & ~e.pe;
        if (e.dv) last_good = d;
        e.pdata = last_good;
        e.cyc   = cyc + 2 + (pen ? 11 : 10) * p;
        e.tol   = tol;
        sb.push_back(e);
        drive_bit(1'b0, p, 1'b0);
        // Disturb the config mid-frame; the receiver must use its latched copy
        Prescale    = (p == 8) ? 6'd16 : 6'd8;
        Parity_type = ~ptype;
        Parity_EN   = ~pen;
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, (glitch_bit == i));
        if (pen) drive_bit(par, p, 1'b0);
        Prescale    = p[5:0];
        Parity_EN   = pen;
        Parity_type = ptype;
        drive_bit(stop_b, p, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        @(negedge CLK);
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset       = 1'b0;
        Rx_in       = 1'b1;
        Prescale    = 6'd8;
        Parity_EN   = 1'b0;
        Parity_type = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_p_data", 32'(P_Data), 32'd0);
        chk("reset_dv", 32'(Data_valid), 32'd0);
        chk("reset_pe", 32'(Parity_error), 32'd0);
        chk("reset_se", 32'(Stop_error), 32'd0);
        @(posedge CLK);
        #1 Reset = 1'b1;
        idle(4);

        // P=8, even parity, exact latency
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
        drain(20);
        idle(4);

        // P=16, odd parity: good frame then a parity error
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
        drain(20);
        idle(4);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
        drain(20);
        idle(4);

        // No parity: stop error, then recovery
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        drain(20);
        idle(4);
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        drain(20);
        idle(4);

        // Parity and stop error in the same frame
        send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0);
        drain(20);
        idle(4);

        // Short start glitch is rejected, next frame still received
        Prescale = 6'd8;
        Rx_in    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        idle(8);
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        drain(20);
        idle(4);

        // P=32 back-to-back frames with single-cycle mid-bit glitches
        send_frame(8'h00, 32, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1);
        send_frame(8'hFF, 32, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1);
        send_frame(8'h81, 32, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1);
        drain(40);
        idle(4);

        // Reset during data bit 4 of 0xC3
        Prescale  = 6'd8;
        Parity_EN = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        Rx_in = 1'b0;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk("midreset_p_data", 32'(P_Data), 32'd0);
        chk("midreset_dv", 32'(Data_valid), 32'd0);
        chk("midreset_pe", 32'(Parity_error), 32'd0);
        chk("midreset_se", 32'(Stop_error), 32'd0);
        @(posedge CLK);
        #1 Rx_in = 1'b1;
        Reset     = 1'b1;
        last_good = 8'h00;
        idle(20);
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        drain(20);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
